// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write arbiter: default parameters, FSM
// encodings and a small index-wrapping helper.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ID_WIDTH   = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;
    localparam int DEF_CNT_WIDTH  = 3;

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_BURST = 1'b1;

    // Works for any requester count, not only powers of two.
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority search: first valid requester at or above rrPtr,
// wrapping around past the top index.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                any_valid,
    output logic [ID_WIDTH-1:0] pick_id
);

    int idx;

    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        any_valid = 1'b0;
        pick_id   = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                any_valid = 1'b1;
                pick_id   = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync FIFO write port between
// NUM_REQ requesters; each grant costs one idle arbitration cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    logic [0:0]           state_q, state_d;
    logic [ID_WIDTH-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [ID_WIDTH-1:0]  pick_id;
    logic [ID_WIDTH-1:0]  next_ptr;
    logic                 any_valid;
    logic                 in_burst;
    logic                 grant_valid;
    logic                 xfer;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .any_valid (any_valid),
        .pick_id   (pick_id)
    );

    assign in_burst    = (state_q == STATE_BURST);
    assign grant_valid = req_valid[grant_q];
    assign xfer        = in_burst && !fifo_full && grant_valid;
    assign cnt_inc     = burst_cnt_q + CNT_WIDTH'(1);
    assign next_ptr    = ID_WIDTH'(wrapInc(int'(grant_q), NUM_REQ));

    // Only the granted requester ever sees ready, and only from registered state.
    always_comb begin
        req_ready = '0;
        if (in_burst) begin
            req_ready[grant_q] = !fifo_full;
        end
    end

    assign fifo_wr_en = xfer;
    assign fifo_data  = req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_id   = grant_q;
    assign busy       = in_burst;

    // A burst ends on its MAX_BURST-th word or as soon as the owner drops
    // valid; a full FIFO simply freezes everything.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (!in_burst) begin
            if (any_valid) begin
                grant_d     = pick_id;
                burst_cnt_d = '0;
                state_d     = STATE_BURST;
            end
        end else if (!grant_valid) begin
            state_d  = STATE_IDLE;
            rr_ptr_d = next_ptr;
        end else if (xfer) begin
            burst_cnt_d = cnt_inc;
            if (cnt_inc == CNT_WIDTH'(MAX_BURST)) begin
                state_d  = STATE_IDLE;
                rr_ptr_d = next_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STATE_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int CNT_WIDTH  = 3;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    int checks = 0;
    int failures = 0;

    int mBusy = 0;
    int mGrant = 0;
    int mWords = 0;
    int mPtr = 0;
    int xfer[NUM_REQ] = '{0, 0, 0, 0};

    int startCnt[NUM_REQ];
    int limit[NUM_REQ];
    int base[NUM_REQ];
    bit randData;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    function automatic int firstFrom(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return 0;
    endfunction

    // Reference: a grant owns the port until it has moved MAX_BURST words
    // or its owner goes quiet; the next search starts just past the owner.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy  <= 0;
            mGrant <= 0;
            mWords <= 0;
            mPtr   <= 0;
        end else if (mBusy == 0) begin
            if (req_valid != '0) begin
                mGrant <= firstFrom(req_valid, mPtr);
                mWords <= 0;
                mBusy  <= 1;
            end
        end else if (!req_valid[mGrant]) begin
            mBusy <= 0;
            mPtr  <= (mGrant + 1) % NUM_REQ;
        end else if (!fifo_full) begin
            xfer[mGrant] <= xfer[mGrant] + 1;
            mWords       <= mWords + 1;
            if (mWords + 1 >= MAX_BURST) begin
                mBusy <= 0;
                mPtr  <= (mGrant + 1) % NUM_REQ;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareModel();
        logic [NUM_REQ-1:0] expReady;
        logic expWr;
        expReady = '0;
        if (mBusy != 0 && !fifo_full) expReady[mGrant] = 1'b1;
        expWr = (mBusy != 0) && req_valid[mGrant] && !fifo_full;
        checkOutput("model_busy", 32'(busy), 32'(mBusy));
        checkOutput("model_grant", 32'(grant_id), 32'(mGrant));
        checkOutput("model_ready", 32'(req_ready), 32'(expReady));
        checkOutput("model_wr_en", 32'(fifo_wr_en), 32'(expWr));
        if (expWr)
            checkOutput("model_data", 32'(fifo_data),
                        32'(req_data[mGrant*DATA_WIDTH +: DATA_WIDTH]));
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] vmask, input logic full,
                                 input logic rstn);
        int sent;
        @(posedge clk);
        #1;
        rst_n     = rstn;
        fifo_full = full;
        for (int i = 0; i < NUM_REQ; i++) begin
            sent = xfer[i] - startCnt[i];
            req_valid[i] = vmask[i] && (sent < limit[i]);
            req_data[i*DATA_WIDTH +: DATA_WIDTH] =
                randData ? DATA_WIDTH'($urandom) : DATA_WIDTH'(base[i] + sent);
        end
        @(negedge clk);
        compareModel();
    endtask

    task automatic startScenario();
        for (int i = 0; i < NUM_REQ; i++) begin
            startCnt[i] = xfer[i];
            limit[i]    = 1000000;
            base[i]     = 16 * i;
        end
    endtask

    int wr032[9]   = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    int busy032[9] = '{0, 1, 1, 1, 1, 0, 1, 1, 1};
    int order033[5] = '{0, 1, 2, 3, 0};

    initial begin
        int nWr;
        int wrCount;
        logic [NUM_REQ-1:0] m;
        logic f;
        logic r;

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        randData  = 1'b0;
        startScenario();

        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_wr_en", 32'(fifo_wr_en), 32'd0);
        checkOutput("reset_grant", 32'(grant_id), 32'd0);

        // Single requester, six words: burst of four, bubble, burst of two.
        startScenario();
        base[0]  = 'hA0;
        limit[0] = 6;
        nWr = 0;
        for (int c = 0; c < 9; c++) begin
            applyStimulus(4'b0001, 1'b0, 1'b1);
            checkOutput($sformatf("s1_wr_c%0d", c), 32'(fifo_wr_en), 32'(wr032[c]));
            checkOutput($sformatf("s1_busy_c%0d", c), 32'(busy), 32'(busy032[c]));
            if (wr032[c] == 1) begin
                checkOutput($sformatf("s1_data_c%0d", c), 32'(fifo_data), 32'('hA0 + nWr));
                nWr++;
            end
        end

        // All requesters busy: grants rotate 0,1,2,3,0 with a bubble between.
        applyStimulus('0, 1'b0, 1'b0);
        startScenario();
        for (int c = 0; c < 25; c++) begin
            applyStimulus(4'b1111, 1'b0, 1'b1);
            if (c % 5 == 1) begin
                checkOutput($sformatf("s2_grant_c%0d", c), 32'(grant_id), 32'(order033[c/5]));
                checkOutput($sformatf("s2_wr_c%0d", c), 32'(fifo_wr_en), 32'd1);
            end else if (c % 5 == 0) begin
                checkOutput($sformatf("s2_bubble_c%0d", c), 32'(fifo_wr_en), 32'd0);
                checkOutput($sformatf("s2_idle_c%0d", c), 32'(busy), 32'd0);
            end
        end

        // FIFO full for three cycles in the middle of requester 2's burst.
        applyStimulus('0, 1'b0, 1'b0);
        startScenario();
        wrCount = 0;
        for (int c = 0; c < 9; c++) begin
            f = (c >= 3 && c <= 5);
            applyStimulus(4'b0100, f, 1'b1);
            wrCount += int'(fifo_wr_en);
            if (f) begin
                checkOutput($sformatf("s3_ready_c%0d", c), 32'(req_ready), 32'd0);
                checkOutput($sformatf("s3_wr_c%0d", c), 32'(fifo_wr_en), 32'd0);
                checkOutput($sformatf("s3_busy_c%0d", c), 32'(busy), 32'd1);
            end
            if (c == 7) checkOutput("s3_wr_c7", 32'(fifo_wr_en), 32'd1);
        end
        checkOutput("s3_end_busy", 32'(busy), 32'd0);
        checkOutput("s3_total_writes", 32'(wrCount), 32'd4);

        // Requester 1 goes quiet after two words; requester 3 takes over.
        applyStimulus('0, 1'b0, 1'b0);
        startScenario();
        limit[1] = 2;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b1010, 1'b0, 1'b1);
            case (c)
                1: checkOutput("s4_grant_c1", 32'(grant_id), 32'd1);
                3: begin
                    checkOutput("s4_wr_c3", 32'(fifo_wr_en), 32'd0);
                    checkOutput("s4_busy_c3", 32'(busy), 32'd1);
                end
                4: begin
                    checkOutput("s4_busy_c4", 32'(busy), 32'd0);
                    checkOutput("s4_lastgrant_c4", 32'(grant_id), 32'd1);
                end
                5: begin
                    checkOutput("s4_grant_c5", 32'(grant_id), 32'd3);
                    checkOutput("s4_wr_c5", 32'(fifo_wr_en), 32'd1);
                end
                default: ;
            endcase
        end

        // Reset lands mid-burst after one word.
        applyStimulus('0, 1'b0, 1'b0);
        startScenario();
        applyStimulus(4'b0100, 1'b0, 1'b1);
        applyStimulus(4'b0100, 1'b0, 1'b1);
        checkOutput("s5_prewr", 32'(fifo_wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_wr", 32'(fifo_wr_en), 32'd0);
        checkOutput("s5_rst_ready", 32'(req_ready), 32'd0);
        checkOutput("s5_rst_busy", 32'(busy), 32'd0);
        checkOutput("s5_rst_grant", 32'(grant_id), 32'd0);
        applyStimulus('0, 1'b0, 1'b0);
        startScenario();
        applyStimulus(4'b1000, 1'b0, 1'b1);
        checkOutput("s5_idle", 32'(busy), 32'd0);
        applyStimulus(4'b1000, 1'b0, 1'b1);
        checkOutput("s5_grant", 32'(grant_id), 32'd3);
        checkOutput("s5_wr", 32'(fifo_wr_en), 32'd1);

        // Random traffic, stalls and occasional resets.
        startScenario();
        randData = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            m = NUM_REQ'($urandom) | NUM_REQ'($urandom);
            f = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 249) != 0);
            applyStimulus(m, f, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
